decodificador_particao: RTL and testbench

//  Inverse of the per-process offset table: takes an absolute memory address and returns
//  the owning process index and the partition-local address.

---
 rtl/decodificador_particao.sv | 97 +++++++++
 tb/tb_decodificador_particao.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/decodificador_particao.sv
// Maps an absolute address to its owning process index and partition-local address.
// Iterative subtract-and-count decode with a Start/Pronto handshake.
module decodificador_particao #(
  parameter int LARGURA       = 32,
  parameter int TAM_PARTICAO  = 150,
  parameter int NUM_PARTICOES = 14
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [LARGURA-1:0] Endereco_Absoluto,
  output logic               Ocupado,
  output logic               Pronto,
  output logic [3:0]         Indice_Processo,
  output logic [LARGURA-1:0] Endereco_Local,
  output logic               Fora_Limite
);

  // state    | meaning
  // OCIOSO   | idle, accepts Start
  // CALC     | subtracting one partition size per cycle
  // FIM_ERRO | address beyond last partition, report error next edge
  typedef enum logic [1:0] {OCIOSO, CALC, FIM_ERRO} estado_t;

  localparam logic [LARGURA-1:0] TAM    = LARGURA'(TAM_PARTICAO);
  localparam logic [LARGURA-1:0] LIMITE = LARGURA'(NUM_PARTICOES * TAM_PARTICAO);

  estado_t            estado, estado_n;
  logic [LARGURA-1:0] resto, resto_n;
  logic [3:0]         cont, cont_n;
  logic               pronto_n;
  logic [3:0]         indice_n;
  logic [LARGURA-1:0] local_n;
  logic               fora_n;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado          <= OCIOSO;
      resto           <= '0;
      cont            <= '0;
      Pronto          <= 1'b0;
      Indice_Processo <= '0;
      Endereco_Local  <= '0;
      Fora_Limite     <= 1'b0;
    end else begin
      estado          <= estado_n;
      resto           <= resto_n;
      cont            <= cont_n;
      Pronto          <= pronto_n;
      Indice_Processo <= indice_n;
      Endereco_Local  <= local_n;
      Fora_Limite     <= fora_n;
    end
  end

  always_comb begin
    estado_n = estado;
    resto_n  = resto;
    cont_n   = cont;
    pronto_n = 1'b0;
    indice_n = Indice_Processo;
    local_n  = Endereco_Local;
    fora_n   = Fora_Limite;
    case (estado)
      OCIOSO: begin
        if (Start) begin
          resto_n  = Endereco_Absoluto;
          cont_n   = '0;
          estado_n = (Endereco_Absoluto >= LIMITE) ? FIM_ERRO : CALC;
        end
      end
      CALC: begin
        if (resto < TAM) begin
          indice_n = cont;
          local_n  = resto;
          fora_n   = 1'b0;
          pronto_n = 1'b1;
          estado_n = OCIOSO;
        end else begin
          resto_n = resto - TAM;
          cont_n  = cont + 4'd1;
        end
      end
      FIM_ERRO: begin
        indice_n = 4'hF;
        local_n  = '0;
        fora_n   = 1'b1;
        pronto_n = 1'b1;
        estado_n = OCIOSO;
      end
      default: estado_n = OCIOSO;
    endcase
  end

  assign Ocupado = (estado != OCIOSO);

endmodule

// File: tb/tb_decodificador_particao.sv
// Directed bench for decodificador_particao: vector table plus multi-cycle corner sequences.
module tb_decodificador_particao;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] Endereco_Absoluto = '0;
  logic        Ocupado;
  logic        Pronto;
  logic [3:0]  Indice_Processo;
  logic [31:0] Endereco_Local;
  logic        Fora_Limite;

  int nvec = 0;
  int nerr = 0;

  decodificador_particao dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .Endereco_Absoluto(Endereco_Absoluto),
    .Ocupado(Ocupado), .Pronto(Pronto), .Indice_Processo(Indice_Processo),
    .Endereco_Local(Endereco_Local), .Fora_Limite(Fora_Limite)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] addr;
    int          lat;
    logic [3:0]  idx;
    logic [31:0] loc;
    logic        fora;
  } vec_t;

  vec_t tab [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_decode(input vec_t v);
    int c;
    @(negedge Clock);
    Start = 1'b1;
    Endereco_Absoluto = v.addr;
    @(posedge Clock); #1;
    Start = 1'b0;
    chk($sformatf("ocupado_after_start a=%0d", v.addr), 32'(Ocupado), 32'd1);
    c = 0;
    while (Pronto !== 1'b1 && c < 40) begin
      if (c > 0) begin @(posedge Clock); #1; end
      c++;
      if (c == 1 && Pronto !== 1'b1) begin @(posedge Clock); #1; c++; end
    end
    // c counts edges after the Start edge until Pronto was seen
    chk($sformatf("latency a=%0d", v.addr), 32'(c - 1), 32'(v.lat));
    chk($sformatf("indice a=%0d", v.addr), 32'(Indice_Processo), 32'(v.idx));
    chk($sformatf("local a=%0d", v.addr), Endereco_Local, v.loc);
    chk($sformatf("fora a=%0d", v.addr), 32'(Fora_Limite), 32'(v.fora));
    chk($sformatf("ocupado_in_pronto a=%0d", v.addr), 32'(Ocupado), 32'd0);
    @(posedge Clock); #1;
    chk($sformatf("pronto_width a=%0d", v.addr), 32'(Pronto), 32'd0);
    chk($sformatf("hold_indice a=%0d", v.addr), 32'(Indice_Processo), 32'(v.idx));
  endtask

  initial begin
    int np, at1, at2;
    logic [3:0]  i1, i2;
    logic [31:0] l1, l2;

    tab[0] = '{32'd0,          1, 4'd0,  32'd0,   1'b0};
    tab[1] = '{32'd1049,       7, 4'd6,  32'd149, 1'b0};
    tab[2] = '{32'd1050,       8, 4'd7,  32'd0,   1'b0};
    tab[3] = '{32'd2099,      14, 4'd13, 32'd149, 1'b0};
    tab[4] = '{32'd2100,       1, 4'hF,  32'd0,   1'b1};
    tab[5] = '{32'd149,        1, 4'd0,  32'd149, 1'b0};
    tab[6] = '{32'hFFFF_FFFF,  1, 4'hF,  32'd0,   1'b1};
    tab[7] = '{32'd150,        2, 4'd1,  32'd0,   1'b0};
    tab[8] = '{32'd1000,       7, 4'd6,  32'd100, 1'b0};

    repeat (2) @(posedge Clock);
    #1;
    chk("reset_ocupado", 32'(Ocupado), 32'd0);
    chk("reset_pronto", 32'(Pronto), 32'd0);
    chk("reset_indice", 32'(Indice_Processo), 32'd0);
    chk("reset_local", Endereco_Local, 32'd0);
    chk("reset_fora", 32'(Fora_Limite), 32'd0);
    Reset = 1'b0;

    foreach (tab[i]) run_decode(tab[i]);

    // Second Start during a decode is dropped
    @(negedge Clock);
    Start = 1'b1; Endereco_Absoluto = 32'd1950;
    @(posedge Clock); #1;
    Start = 1'b0;
    np = 0; at1 = 0; i1 = '0; l1 = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin Start = 1'b1; Endereco_Absoluto = 32'd0; end
      else Start = 1'b0;
      @(posedge Clock); #1;
      if (Pronto === 1'b1) begin
        np++;
        if (np == 1) begin at1 = c; i1 = Indice_Processo; l1 = Endereco_Local; end
      end
    end
    Start = 1'b0;
    chk("ignored_start_npronto", 32'(np), 32'd1);
    chk("ignored_start_latency", 32'(at1), 32'd14);
    chk("ignored_start_indice", 32'(i1), 32'd13);
    chk("ignored_start_local", l1, 32'd0);

    // Reset mid-decode aborts without Pronto
    @(negedge Clock);
    Start = 1'b1; Endereco_Absoluto = 32'd1500;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (4) begin @(posedge Clock); #1; end
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    chk("abort_ocupado", 32'(Ocupado), 32'd0);
    chk("abort_pronto", 32'(Pronto), 32'd0);
    chk("abort_indice", 32'(Indice_Processo), 32'd0);
    chk("abort_local", Endereco_Local, 32'd0);
    chk("abort_fora", 32'(Fora_Limite), 32'd0);
    np = 0;
    repeat (15) begin
      @(posedge Clock); #1;
      if (Pronto === 1'b1 || Ocupado === 1'b1) np++;
    end
    chk("abort_no_activity", 32'(np), 32'd0);

    // Start held high: back-to-back decodes
    @(negedge Clock);
    Start = 1'b1; Endereco_Absoluto = 32'd300;
    @(posedge Clock); #1;
    np = 0; at1 = 0; at2 = 0; i1 = '0; i2 = '0; l1 = '0; l2 = '0;
    for (int c = 1; c <= 30 && np < 2; c++) begin
      @(posedge Clock); #1;
      if (Pronto === 1'b1) begin
        np++;
        if (np == 1) begin
          at1 = c; i1 = Indice_Processo; l1 = Endereco_Local;
          Endereco_Absoluto = 32'd151;
        end else begin
          at2 = c; i2 = Indice_Processo; l2 = Endereco_Local;
        end
      end
    end
    Start = 1'b0;
    chk("b2b_npronto", 32'(np), 32'd2);
    chk("b2b_first_latency", 32'(at1), 32'd3);
    chk("b2b_first_indice", 32'(i1), 32'd2);
    chk("b2b_first_local", l1, 32'd0);
    chk("b2b_second_latency", 32'(at2 - at1), 32'd3);
    chk("b2b_second_indice", 32'(i2), 32'd1);
    chk("b2b_second_local", l2, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
